// File: rtl/scan_test_controller.sv
// scan_test_controller
//   Runs one scan test per accepted start: shifts CHAIN_LEN pattern bits into
//   the attached scan chain, issues a single capture cycle, shifts the
//   response back out and compares it with the latched expected vector.
//
//   Parameters
//     CHAIN_LEN  flip-flops in the attached scan chain (>= 2)
//     CNT_W      shift counter width, 2**CNT_W > CHAIN_LEN
//
//   Ports
//     clk_i         system clock, rising edge
//     rst_i         asynchronous, active-high reset
//     start_i       begin a test (sampled only while idle)
//     pattern_i     stimulus vector, latched on start acceptance
//     expected_i    golden response, latched on start acceptance
//     scan_out_i    serial output of the chain's last flip-flop
//     scan_in_o     serial input to the chain
//     scan_en_o     1 = shift, 0 = capture/functional
//     busy_o        high from start acceptance until done
//     done_o        one-cycle pulse when the result is valid
//     pass_o        captured_o == expected, held until the next start
//     captured_o    response shifted out, held until the next start
module scan_test_controller #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CHAIN_LEN-1:0] pattern_i,
    input  logic [CHAIN_LEN-1:0] expected_i,
    input  logic                 scan_out_i,
    output logic                 scan_in_o,
    output logic                 scan_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CHAIN_LEN-1:0] captured_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic                 scan_in_q;
    logic                 scan_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CHAIN_LEN-1:0] captured_q;

    logic                 last_cnt;
    logic                 load_bit_d;
    logic [CHAIN_LEN-1:0] captured_d;
    logic                 pass_d;

    assign scan_in_o  = scan_in_q;
    assign scan_en_o  = scan_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign captured_o = captured_q;

    assign last_cnt = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    // load_bit_d: pattern bit for the next LOAD cycle (cnt+1), i.e.
    // pat[CHAIN_LEN-2-cnt]. captured_d: captured with scan_out written to
    // bit CHAIN_LEN-1-cnt, so the final compare sees the last sampled bit.
    always_comb begin
        load_bit_d = 1'b0;
        captured_d = captured_q;
        for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
            if (i + 2 + 32'(cnt_q) == CHAIN_LEN) load_bit_d = pat_q[i];
            if (i + 1 + 32'(cnt_q) == CHAIN_LEN) captured_d[i] = scan_out_i;
        end
        pass_d = (captured_d == exp_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            exp_q      <= '0;
            scan_in_q  <= 1'b0;
            scan_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (start_i) begin
                        pat_q      <= pattern_i;
                        exp_q      <= expected_i;
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        captured_q <= '0;
                        scan_en_q  <= 1'b1;
                        scan_in_q  <= pattern_i[CHAIN_LEN-1];
                    end
                end
                S_LOAD: begin
                    if (last_cnt) begin
                        state_q   <= S_CAPTURE;
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        scan_in_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        scan_in_q <= load_bit_d;
                    end
                end
                S_CAPTURE: begin
                    state_q   <= S_UNLOAD;
                    cnt_q     <= '0;
                    scan_en_q <= 1'b1;
                    scan_in_q <= 1'b0;
                end
                S_UNLOAD: begin
                    captured_q <= captured_d;
                    if (last_cnt) begin
                        state_q   <= S_DONE;
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= pass_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: drives it against a behavioural scan chain
// (loopback-invert capture, or a 4x4 multiplier capture) and compares results
// with a reference derived directly from the test rules.
module tb_scan_test_controller;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic         scan_out;
    logic         scan_in;
    logic         scan_en;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N-1:0] captured;

    int checks = 0;
    int errors = 0;

    // chain model
    logic         mult_mode = 1'b0;
    logic [N-1:0] chain = '0;

    // transaction record
    int           acc_edges;
    int           done_cycle;
    int           done_count;
    logic [N-1:0] res_cap;
    logic         res_pass;
    logic         en_log   [0:31];
    logic         in_log   [0:31];
    logic         busy_log [0:31];

    assign rst = ~rst_n;
    always #5 clk = ~clk;

    scan_test_controller #(.CHAIN_LEN(N), .CNT_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .pattern_i  (pattern),
        .expected_i (expected),
        .scan_out_i (scan_out),
        .scan_in_o  (scan_in),
        .scan_en_o  (scan_en),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .captured_o (captured)
    );

    // Shift toward bit N-1; capture either inverts or loads a[7:4]*b[3:0].
    always @(posedge clk) begin
        if (scan_en)        chain <= {chain[N-2:0], scan_in};
        else if (mult_mode) chain <= 8'(chain[7:4]) * 8'(chain[3:0]);
        else                chain <= ~chain;
    end
    assign scan_out = chain[N-1];

    function automatic logic [N-1:0] ref_resp(input logic mm, input logic [N-1:0] p);
        logic [N-1:0] r;
        if (mm) r = 8'(int'(p[7:4]) * int'(p[3:0]));
        else    r = ~p;
        return r;
    endfunction

    // Starts one test and records per-cycle outputs (cycle 1 = first cycle
    // after the accepting edge). No comparisons here.
    task automatic run_txn(input logic [N-1:0] pat, input logic [N-1:0] exv,
                           input int intr_cycle, input logic [N-1:0] intr_pat,
                           input bit stop_at_done);
        bit accepted;
        accepted   = 1'b0;
        acc_edges  = 0;
        done_cycle = 0;
        done_count = 0;
        res_cap    = '0;
        res_pass   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            en_log[i] = 1'b0; in_log[i] = 1'b0; busy_log[i] = 1'b0;
        end
        pattern  = pat;
        expected = exv;
        start    = 1'b1;
        for (int e = 0; e < 6 && !accepted; e++) begin
            @(posedge clk); #1;
            acc_edges++;
            if (busy) accepted = 1'b1;
        end
        start    = 1'b0;
        pattern  = N'($urandom);
        expected = N'($urandom);
        if (accepted) begin
            for (int c = 1; c <= 30; c++) begin
                en_log[c]   = scan_en;
                in_log[c]   = scan_in;
                busy_log[c] = busy;
                if (done) done_count++;
                if (done && done_cycle == 0) begin
                    done_cycle = c;
                    res_cap    = captured;
                    res_pass   = pass;
                end
                if (c == intr_cycle) begin
                    start    = 1'b1;
                    pattern  = intr_pat;
                    expected = intr_pat;
                end else begin
                    start = 1'b0;
                end
                if (done_cycle != 0 && (stop_at_done || c >= done_cycle + 1)) break;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_power_on_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({scan_en, scan_in, busy, done, pass, captured} !== '0) begin
            errors++;
            $display("FAIL por_outputs got en=%b in=%b busy=%b done=%b pass=%b cap=%h want all 0",
                     scan_en, scan_in, busy, done, pass, captured);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({scan_en, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL por_release got en=%b busy=%b done=%b want 000", scan_en, busy, done);
        end
    endtask

    task automatic test_basic;
        logic [N-1:0]     pat;
        logic [2*N+1:0]   got_en, want_en, got_in, want_in, got_busy, want_busy;
        pat = 8'hA7;
        mult_mode = 1'b0;
        run_txn(pat, 8'h58, 0, '0, 1'b0);
        got_en = '0; want_en = '0; got_in = '0; want_in = '0; got_busy = '0; want_busy = '0;
        for (int c = 1; c <= 2 * N + 2; c++) begin
            got_en[c-1]    = en_log[c];
            want_en[c-1]   = (c <= N) || (c >= N + 2 && c <= 2 * N + 1);
            got_in[c-1]    = in_log[c];
            want_in[c-1]   = (c <= N) ? pat[N-c] : 1'b0;
            got_busy[c-1]  = busy_log[c];
            want_busy[c-1] = (c <= 2 * N + 1);
        end
        checks++;
        if (acc_edges !== 1) begin
            errors++; $display("FAIL basic_accept got %0d edges want 1", acc_edges);
        end
        checks++;
        if (got_en !== want_en) begin
            errors++; $display("FAIL basic_scan_en got %b want %b", got_en, want_en);
        end
        checks++;
        if (got_in !== want_in) begin
            errors++; $display("FAIL basic_scan_in got %b want %b", got_in, want_in);
        end
        checks++;
        if (got_busy !== want_busy) begin
            errors++; $display("FAIL basic_busy got %b want %b", got_busy, want_busy);
        end
        checks++;
        if (done_cycle !== 2 * N + 2) begin
            errors++; $display("FAIL basic_latency got %0d want %0d", done_cycle, 2 * N + 2);
        end
        checks++;
        if (done_count !== 1) begin
            errors++; $display("FAIL basic_done_pulses got %0d want 1", done_count);
        end
        checks++;
        if (res_cap !== 8'h58 || res_pass !== 1'b1) begin
            errors++; $display("FAIL basic_result got cap=%h pass=%b want cap=58 pass=1", res_cap, res_pass);
        end
        checks++;
        if (captured !== 8'h58 || pass !== 1'b1) begin
            errors++; $display("FAIL basic_hold got cap=%h pass=%b want cap=58 pass=1", captured, pass);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scan_en, scan_in, busy, done, pass, captured} !== '0) begin
            errors++;
            $display("FAIL idle_reset_async got en=%b in=%b busy=%b done=%b pass=%b cap=%h want all 0",
                     scan_en, scan_in, busy, done, pass, captured);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({scan_en, busy, done, pass, captured} !== '0) begin
            errors++;
            $display("FAIL idle_reset_release got en=%b busy=%b done=%b pass=%b cap=%h want all 0",
                     scan_en, busy, done, pass, captured);
        end
    endtask

    task automatic test_mismatch;
        mult_mode = 1'b0;
        run_txn(8'h96, 8'h00, 0, '0, 1'b0);
        checks++;
        if (res_cap !== 8'h69 || res_pass !== 1'b0) begin
            errors++; $display("FAIL mismatch_result got cap=%h pass=%b want cap=69 pass=0", res_cap, res_pass);
        end
        checks++;
        if (done_count !== 1 || done_cycle !== 2 * N + 2) begin
            errors++; $display("FAIL mismatch_done got count=%0d cycle=%0d want 1/%0d",
                               done_count, done_cycle, 2 * N + 2);
        end
    endtask

    task automatic test_busy;
        logic [2*N:0] got_busy;
        mult_mode = 1'b0;
        // start pulse seen at the edge ending UNLOAD cycle 2
        run_txn(8'h12, 8'hED, N + 4, 8'hFF, 1'b1);
        got_busy = '0;
        for (int c = 1; c <= 2 * N + 1; c++) got_busy[c-1] = busy_log[c];
        checks++;
        if (got_busy !== '1) begin
            errors++; $display("FAIL busy_held got %b want all 1", got_busy);
        end
        checks++;
        if (res_cap !== 8'hED || res_pass !== 1'b1 || done_cycle !== 2 * N + 2) begin
            errors++; $display("FAIL busy_ignore got cap=%h pass=%b cycle=%0d want ED/1/%0d",
                               res_cap, res_pass, done_cycle, 2 * N + 2);
        end
    endtask

    task automatic test_back_to_back;
        // called right in the DONE cycle of test_busy: start there is ignored
        run_txn(8'h81, 8'h7E, 0, '0, 1'b0);
        checks++;
        if (acc_edges !== 2) begin
            errors++; $display("FAIL b2b_accept got %0d edges want 2", acc_edges);
        end
        checks++;
        if (done_cycle !== 2 * N + 2 || done_count !== 1) begin
            errors++; $display("FAIL b2b_latency got cycle=%0d count=%0d want %0d/1",
                               done_cycle, done_count, 2 * N + 2);
        end
        checks++;
        if (res_cap !== 8'h7E || res_pass !== 1'b1) begin
            errors++; $display("FAIL b2b_result got cap=%h pass=%b want 7E/1", res_cap, res_pass);
        end
    endtask

    task automatic test_reset_midop;
        int dones;
        bit acc;
        mult_mode = 1'b0;
        dones = 0;
        acc = 1'b0;
        pattern = 8'h5A;
        expected = 8'hA5;
        start = 1'b1;
        for (int e = 0; e < 6 && !acc; e++) begin
            @(posedge clk); #1;
            if (busy) acc = 1'b1;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (scan_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midop_in_load got en=%b busy=%b want 1/1", scan_en, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scan_en, scan_in, busy, done, pass, captured} !== '0) begin
            errors++;
            $display("FAIL midop_async got en=%b in=%b busy=%b done=%b pass=%b cap=%h want all 0",
                     scan_en, scan_in, busy, done, pass, captured);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * N + 4; c++) begin
            @(posedge clk); #1;
            if (done || scan_en) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL midop_no_done got %0d activity cycles want 0", dones);
        end
        run_txn(8'h3C, 8'hC3, 0, '0, 1'b0);
        checks++;
        if (res_cap !== 8'hC3 || res_pass !== 1'b1 || done_cycle !== 2 * N + 2) begin
            errors++; $display("FAIL midop_rerun got cap=%h pass=%b cycle=%0d want C3/1/%0d",
                               res_cap, res_pass, done_cycle, 2 * N + 2);
        end
    endtask

    task automatic test_random_loopback;
        logic [N-1:0] p, r, e;
        mult_mode = 1'b0;
        for (int t = 0; t < 20; t++) begin
            p = N'($urandom);
            r = ref_resp(1'b0, p);
            e = ($urandom_range(0, 1) == 0) ? r : N'($urandom);
            run_txn(p, e, 0, '0, 1'b0);
            checks++;
            if (res_cap !== r || res_pass !== (r == e) || done_cycle !== 2 * N + 2) begin
                errors++;
                $display("FAIL rand_loop[%0d] pat=%h got cap=%h pass=%b cycle=%0d want cap=%h pass=%b cycle=%0d",
                         t, p, res_cap, res_pass, done_cycle, r, (r == e), 2 * N + 2);
            end
        end
    endtask

    task automatic test_real_chain;
        logic [N-1:0] p, r, e;
        mult_mode = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                p = N'((a << 4) | b);
                r = ref_resp(1'b1, p);
                run_txn(p, r, 0, '0, 1'b0);
                checks++;
                if (res_cap !== r || res_pass !== 1'b1 || done_cycle !== 2 * N + 2) begin
                    errors++;
                    $display("FAIL mult a=%0d b=%0d got cap=%h pass=%b cycle=%0d want cap=%h pass=1 cycle=%0d",
                             a, b, res_cap, res_pass, done_cycle, r, 2 * N + 2);
                end
            end
        end
        for (int t = 0; t < 8; t++) begin
            p = N'($urandom);
            r = ref_resp(1'b1, p);
            e = r ^ N'(1 << $urandom_range(0, N - 1));
            run_txn(p, e, 0, '0, 1'b0);
            checks++;
            if (res_cap !== r || res_pass !== 1'b0) begin
                errors++;
                $display("FAIL mult_bad[%0d] pat=%h got cap=%h pass=%b want cap=%h pass=0",
                         t, p, res_cap, res_pass, r);
            end
        end
        mult_mode = 1'b0;
    endtask

    initial begin
        test_power_on_reset();
        test_basic();
        test_reset();
        test_mismatch();
        test_busy();
        test_back_to_back();
        test_reset_midop();
        test_random_loopback();
        test_real_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
